// File: rtl/requant_pkg.sv
// requant_pkg: shared constants, types and FSM encodings for the requantizer gain controller
package requant_pkg;
  localparam int N_CHAN_DEF = 2048;
  localparam int ADDR_W_DEF = 11;
  localparam int GAIN_W_DEF = 18;
  typedef logic [GAIN_W_DEF-1:0] gain_t;
  typedef logic [ADDR_W_DEF-1:0] chan_t;
  typedef enum logic {S_IDLE, S_PEND} swap_state_t;
  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RUN} run_state_t;
endpackage

// File: rtl/requant_gain_ctrl_if.sv
// requant_gain_ctrl_if: host and requantizer signals of the gain controller; REQUANT_GAIN_READBACK_EN adds shadow readback
interface requant_gain_ctrl_if #(
  parameter int ADDR_W    = 11,
  parameter int GAIN_W    = 18,
  parameter int OVF_CNT_W = 16
);
  logic                 ce;
  logic                 host_wr_en;
  logic [ADDR_W-1:0]    host_wr_addr;
  logic [GAIN_W-1:0]    host_wr_data;
  logic                 host_commit;
  logic                 host_start;
  logic                 host_ovf_clear;
  logic                 host_busy;
  logic                 host_wr_drop;
  logic [ADDR_W-1:0]    addr;
  logic [GAIN_W-1:0]    gain;
  logic                 arm;
  logic                 sync_in;
  logic                 overflow;
  logic                 running;
  logic                 active_bank;
  logic [OVF_CNT_W-1:0] ovf_count;
`ifdef REQUANT_GAIN_READBACK_EN
  logic [ADDR_W-1:0]    host_rd_addr;
  logic [GAIN_W-1:0]    host_rd_data;
`endif
  modport master (
    output ce, host_wr_en, host_wr_addr, host_wr_data, host_commit, host_start, host_ovf_clear,
    output addr, sync_in, overflow,
`ifdef REQUANT_GAIN_READBACK_EN
    output host_rd_addr, input host_rd_data,
`endif
    input host_busy, host_wr_drop, gain, arm, running, active_bank, ovf_count
  );
  modport slave (
    input ce, host_wr_en, host_wr_addr, host_wr_data, host_commit, host_start, host_ovf_clear,
    input addr, sync_in, overflow,
`ifdef REQUANT_GAIN_READBACK_EN
    input host_rd_addr, output host_rd_data,
`endif
    output host_busy, host_wr_drop, gain, arm, running, active_bank, ovf_count
  );
endinterface

// File: rtl/gain_bank_ram.sv
// gain_bank_ram: simple dual-port gain array with registered read; REQUANT_GAIN_READBACK_EN adds a second read port
module gain_bank_ram #(
  parameter int DEPTH = 4096,
  parameter int AW    = 12,
  parameter int W     = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
`ifdef REQUANT_GAIN_READBACK_EN
  input  logic          pre,
  input  logic [AW-1:0] praddr,
  output logic [W-1:0]  prdata,
`endif
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  // only the output registers reset; the array contents stay undefined
  always_ff @(posedge clk)
    if (rst) rdata <= '0;
    else if (re) rdata <= mem[raddr];
`ifdef REQUANT_GAIN_READBACK_EN
  always_ff @(posedge clk)
    if (rst) prdata <= '0;
    else if (pre) prdata <= mem[praddr];
`endif
endmodule

// File: rtl/requant_gain_ctrl.sv
// requant_gain_ctrl: double-buffered gain table, frame-aligned bank swap, arm/run sequencing, overflow count.
// Optional host readback of the shadow bank via REQUANT_GAIN_READBACK_EN.
module requant_gain_ctrl
  import requant_pkg::*;
#(
  parameter int N_CHAN    = N_CHAN_DEF,
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int GAIN_W    = GAIN_W_DEF,
  parameter int OVF_CNT_W = 16
) (
  input logic clk,
  input logic rst,
  requant_gain_ctrl_if.slave bus
);
  swap_state_t swap_q, swap_d;
  run_state_t run_q, run_d;
  logic bank_q, bank_d, busy_q, busy_d, drop_q, drop_d;
  logic arm_q, arm_d, running_q, running_d, pend_q, pend_d;
  logic [OVF_CNT_W-1:0] ovf_q, ovf_d;
  logic we, swap_now, start;
  always_comb begin
    we = bus.host_wr_en & ~busy_q;
    swap_now = (bus.ce & (bus.addr == ADDR_W'(N_CHAN - 1))) | ~running_q;
    swap_d = (swap_q == S_IDLE) ? (bus.host_commit ? S_PEND : S_IDLE) : (swap_now ? S_IDLE : S_PEND);
    busy_d = swap_d == S_PEND;
    bank_d = bank_q ^ ((swap_q == S_PEND) & swap_now);
    drop_d = drop_q | (bus.host_wr_en & busy_q);
    start = bus.host_start | pend_q;
    pend_d = ~bus.ce & start;
    arm_d = bus.ce & start & (run_q != R_WAIT);
    run_d = arm_d ? R_WAIT : ((run_q == R_WAIT) && bus.ce && bus.sync_in) ? R_RUN : run_q;
    running_d = run_d == R_RUN;
    ovf_d = bus.host_ovf_clear ? '0 : ovf_q + OVF_CNT_W'(bus.ce & bus.overflow & running_q & ~&ovf_q);
  end
  always_ff @(posedge clk)
    if (rst) begin
      swap_q <= S_IDLE;
      run_q <= R_IDLE;
      {bank_q, busy_q, drop_q, arm_q, running_q, pend_q} <= '0;
      ovf_q <= '0;
    end else begin
      swap_q <= swap_d;
      run_q <= run_d;
      {bank_q, busy_q, drop_q, arm_q, running_q, pend_q} <= {bank_d, busy_d, drop_d, arm_d, running_d, pend_d};
      ovf_q <= ovf_d;
    end
  gain_bank_ram #(.DEPTH(2 * N_CHAN), .AW(ADDR_W + 1), .W(GAIN_W)) u_ram (
    .clk   (clk),
    .rst   (rst),
    .we    (we),
    .waddr ({~bank_q, bus.host_wr_addr}),
    .wdata (bus.host_wr_data),
    .re    (bus.ce),
    .raddr ({bank_q, bus.addr}),
`ifdef REQUANT_GAIN_READBACK_EN
    .pre   (~we),
    .praddr({~bank_q, bus.host_rd_addr}),
    .prdata(bus.host_rd_data),
`endif
    .rdata (bus.gain)
  );
  assign bus.host_busy = busy_q;
  assign bus.host_wr_drop = drop_q;
  assign bus.arm = arm_q;
  assign bus.running = running_q;
  assign bus.active_bank = bank_q;
  assign bus.ovf_count = ovf_q;
endmodule

// File: tb/tb_requant_gain_ctrl.sv
// tb_requant_gain_ctrl: directed stimulus pushes expectations into a queue; a negedge monitor pops and compares.
module tb_requant_gain_ctrl;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  requant_gain_ctrl_if bus ();
  requant_gain_ctrl dut (.clk(clk), .rst(rst), .bus(bus));
  typedef struct {string name; int sel; int val; int due;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, cyc = 0;
  localparam int GAIN = 0, ARM = 1, RUN = 2, BANK = 3, BUSY = 4, DROP = 5, OVF = 6;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int obs(int s);
    case (s)
      GAIN: return int'(bus.gain);
      ARM:  return int'(bus.arm);
      RUN:  return int'(bus.running);
      BANK: return int'(bus.active_bank);
      BUSY: return int'(bus.host_busy);
      DROP: return int'(bus.host_wr_drop);
      default: return int'(bus.ovf_count);
    endcase
  endfunction
  always @(negedge clk)
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      int got;
      e = q.pop_front();
      got = obs(e.sel);
      tests++;
      if (got != e.val) begin
        fails++;
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, got, e.val, cyc);
      end
    end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(string n, int s, int v);
    exp_t e;
    e.name = n; e.sel = s; e.val = v; e.due = cyc;
    q.push_back(e);
  endtask
  task automatic wr(int a, int d);
    bus.host_wr_en = 1; bus.host_wr_addr = 11'(a); bus.host_wr_data = 18'(d);
    step();
    bus.host_wr_en = 0;
  endtask
  initial begin
    bus.ce = 0; bus.host_wr_en = 0; bus.host_wr_addr = '0; bus.host_wr_data = '0;
    bus.host_commit = 0; bus.host_start = 0; bus.host_ovf_clear = 0;
    bus.addr = '0; bus.sync_in = 0; bus.overflow = 0;
    step(); step();
    chk("rst_gain", GAIN, 0); chk("rst_arm", ARM, 0); chk("rst_running", RUN, 0);
    chk("rst_bank", BANK, 0); chk("rst_busy", BUSY, 0); chk("rst_drop", DROP, 0); chk("rst_ovf", OVF, 0);
    rst = 0;
    step();
    wr(5, 'h100); wr(0, 'h111); wr(2047, 'h1FF);
    bus.host_commit = 1;
    step();
    chk("idle_commit_busy", BUSY, 1); chk("idle_commit_bank_old", BANK, 0);
    bus.host_commit = 0;
    step();
    chk("idle_swap_busy_clr", BUSY, 0); chk("idle_swap_bank", BANK, 1);
    bus.ce = 1; bus.addr = 5;
    step();
    chk("gain_ch5_new_bank", GAIN, 'h100);
    bus.ce = 0; bus.addr = 0;
    step();
    chk("gain_hold_ce0", GAIN, 'h100);
    wr(0, 'hA0); wr(2047, 'hB0);
    bus.host_start = 1;
    step();
    chk("arm_not_on_ce0", ARM, 0);
    bus.host_start = 0;
    step();
    chk("arm_pending_ce0", ARM, 0);
    bus.ce = 1;
    step();
    chk("arm_on_ce", ARM, 1);
    step();
    chk("arm_single", ARM, 0); chk("wait_not_running", RUN, 0);
    bus.sync_in = 1;
    step();
    chk("sync_running", RUN, 1);
    bus.sync_in = 0;
    for (int a = 0; a < 2048; a++) begin
      bus.addr = 11'(a);
      bus.host_commit = (a == 100);
      step();
      if (a == 0) chk("sweep_old_ch0", GAIN, 'h111);
      if (a == 5) chk("sweep_old_ch5", GAIN, 'h100);
      if (a == 100) chk("sweep_busy_set", BUSY, 1);
      if (a == 2046) begin chk("sweep_busy_hold", BUSY, 1); chk("sweep_bank_hold", BANK, 1); end
      if (a == 2047) begin
        chk("sweep_old_last", GAIN, 'h1FF); chk("sweep_bank_new", BANK, 0); chk("sweep_busy_clr", BUSY, 0);
      end
    end
    bus.host_commit = 0;
    bus.addr = 0;
    step();
    chk("sweep_new_ch0", GAIN, 'hA0);
    bus.host_commit = 1;
    step();
    bus.host_commit = 0;
    chk("pend_busy", BUSY, 1);
    wr(5, 'h555);
    chk("drop_set", DROP, 1);
    bus.addr = 11'(2047);
    step();
    chk("pend_swap_bank", BANK, 1);
    bus.addr = 5;
    step();
    chk("dropped_write_absent", GAIN, 'h100);
    bus.addr = 0;
    bus.host_commit = 1;
    wr(9, 'h999);
    bus.host_commit = 0;
    chk("wr_commit_busy", BUSY, 1);
    bus.addr = 11'(2047);
    step();
    chk("wr_commit_bank", BANK, 0);
    bus.addr = 9;
    step();
    chk("wr_commit_visible", GAIN, 'h999); chk("drop_sticky", DROP, 1);
    bus.host_start = 1;
    step();
    chk("rearm_pulse", ARM, 1); chk("rearm_not_running", RUN, 0);
    bus.host_start = 0;
    step();
    chk("rearm_single", ARM, 0);
    bus.sync_in = 1;
    step();
    bus.sync_in = 0;
    chk("resync_running", RUN, 1);
    bus.overflow = 1;
    step();
    chk("ovf_first", OVF, 1);
    repeat (66000) step();
    chk("ovf_saturate", OVF, 'hFFFF);
    bus.host_ovf_clear = 1;
    step();
    chk("ovf_clear_priority", OVF, 0);
    bus.host_ovf_clear = 0; bus.overflow = 0;
    bus.addr = 11'(2047); bus.host_commit = 1;
    step();
    bus.host_commit = 0;
    step();
    chk("pre_rst_bank", BANK, 1);
    bus.addr = 0; bus.host_commit = 1;
    step();
    bus.host_commit = 0;
    chk("pre_rst_busy", BUSY, 1);
    rst = 1;
    step();
    chk("midswap_rst_bank", BANK, 0); chk("midswap_rst_busy", BUSY, 0);
    chk("midswap_rst_running", RUN, 0); chk("midswap_rst_gain", GAIN, 0); chk("midswap_rst_drop", DROP, 0);
    rst = 0;
    step(); step();
    if (q.size() > 0) begin
      $display("FAIL scoreboard_drain: got %0d pending expected 0", q.size());
      fails += q.size();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
